// File: rtl/geofence_loader.sv
// Serial loader for the hexagon sort stage: collects an object point plus six receiver
// points, fires finish_load, then holds everything until the sort stage answers or times out.
module geofence_loader #(
    parameter int COORD_W = 10,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [COORD_W-1:0]     X,
    input  logic [COORD_W-1:0]     Y,
    input  logic                   finish_sort,
    output logic                   busy,
    output logic [2*COORD_W-1:0]   obj,
    output logic [2*COORD_W-1:0]   G1,
    output logic [2*COORD_W-1:0]   G2,
    output logic [2*COORD_W-1:0]   G3,
    output logic [2*COORD_W-1:0]   G4,
    output logic [2*COORD_W-1:0]   G5,
    output logic [2*COORD_W-1:0]   G6,
    output logic                   finish_load,
    output logic                   err
);

    localparam int PW = 2 * COORD_W;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT_SORT
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            busy_q, busy_d;
    logic            load_q, load_d;
    logic            err_q, err_d;
    logic [PW-1:0]   obj_q, obj_d;
    logic [PW-1:0]   g_q [6];
    logic [PW-1:0]   g_d [6];

    logic            accept;
    logic [PW-1:0]   point;

    assign accept = in_valid & ~busy_q;
    assign point  = {X, Y};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            obj_q   <= '0;
            for (int i = 0; i < 6; i++) begin
                g_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            load_q  <= load_d;
            err_q   <= err_d;
            obj_q   <= obj_d;
            for (int i = 0; i < 6; i++) begin
                g_q[i] <= g_d[i];
            end
        end
    end

    // busy is registered, so it is raised on the same edge as finish_load and
    // dropped on the edge that leaves WAIT_SORT; accept only ever sees busy_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        busy_d  = busy_q;
        load_d  = 1'b0;
        err_d   = err_q;
        obj_d   = obj_q;
        for (int i = 0; i < 6; i++) begin
            g_d[i] = g_q[i];
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (accept) begin
                    obj_d   = point;
                    cnt_d   = 3'd1;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    err_d = 1'b0;
                    for (int i = 0; i < 6; i++) begin
                        if (cnt_q == 3'(i + 1)) begin
                            g_d[i] = point;
                        end
                    end
                    if (cnt_q == 3'd6) begin
                        cnt_d   = 3'd0;
                        busy_d  = 1'b1;
                        load_d  = 1'b1;
                        state_d = FIRE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            FIRE: begin
                busy_d  = 1'b1;
                timer_d = '0;
                state_d = WAIT_SORT;
            end
            WAIT_SORT: begin
                timer_d = timer_q + TW'(1);
                if (finish_sort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign finish_load = load_q;
    assign err         = err_q;
    assign obj         = obj_q;
    assign G1          = g_q[0];
    assign G2          = g_q[1];
    assign G3          = g_q[2];
    assign G4          = g_q[3];
    assign G5          = g_q[4];
    assign G6          = g_q[5];

endmodule

// File: doc/geofence_loader.md
Name: geofence_loader

Overview:
- Front-end producer for the hexagon sort stage.
- Accepts a serial stream of 7 coordinate points: the object point first, then 6 receiver points.
- Packs the points into G1..G6 and the object register, then issues a one-cycle finish_load pulse.
- Holds all point registers stable until the sort stage returns its one-cycle finish_sort pulse. It is the initiator side of the finish_load/finish_sort handshake.

Parameters:
COORD_W, 10, width of each X/Y coordinate; the packed point is 2*COORD_W bits
TIMEOUT, 64, maximum cycles spent in WAIT_SORT before aborting; must be >= 16

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous reset, active-low (0 = reset asserted)
in_valid  input  1  X/Y carry a point this cycle
X  input  COORD_W  point x coordinate
Y  input  COORD_W  point y coordinate
finish_sort  input  1  one-cycle pulse from sort stage: sort complete
busy  output  1  registered; 1 = input stream not accepted
obj  output  2*COORD_W  object point {X,Y}
G1..G6  output  2*COORD_W each  receiver points {X,Y}: x in upper half, y in lower half
finish_load  output  1  registered one-cycle pulse: G1..G6 valid, start sort
err  output  1  sticky timeout flag; cleared by reset or by the next accepted point

Behaviour:
- Reset (reset==0, asynchronous): state IDLE, cnt=0, busy=0, finish_load=0, err=0, obj=0, G1..G6=0.
- Accept condition: in_valid & ~busy at a rising edge. Points with in_valid=1 while busy=1 are dropped silently.
- cnt (3 bits) counts accepted points, 0..6. Point at cnt=0 goes to obj; cnt=k (1..6) goes to Gk. The write of {X,Y} happens on the accept edge.
- Gaps in in_valid between points are allowed; cnt and stored points hold.
- State IDLE: busy=0, waiting for the first point. On accept: write obj, cnt<=1, go to LOAD, err<=0.
- State LOAD: on accept, write G[cnt] and cnt<=cnt+1. When the accepted point has cnt==6:
  - go to FIRE
  - busy<=1 and finish_load<=1 on the same edge, so both are visible the cycle after the 7th point
  - cnt<=0
- State FIRE (1 cycle): finish_load<=0, go to WAIT_SORT, timer<=0.
- State WAIT_SORT:
  - busy=1, all point registers frozen, timer increments each cycle.
  - finish_sort=1: go to IDLE, busy<=0. The first new point can be accepted the cycle after finish_sort.
  - Otherwise, timer==TIMEOUT-1: err<=1, go to IDLE, busy<=0. Point registers keep their values.
- finish_sort in IDLE, LOAD or FIRE: ignored, with no effect on any state or output.
- finish_load is high for exactly one cycle per 7-point round and never high in two consecutive cycles.
- obj and G1..G6 change only on accept edges and on reset; they never change while busy=1.
- Reset mid-round (any state): immediate return to reset values. A partially loaded round is discarded, and no finish_load is issued.
- Downstream sort timing contract: finish_load is followed by finish_sort 14 cycles later. TIMEOUT must exceed this.

Test Plan:
- Reset released, 7 back-to-back points (10,20),(1,1),(5,3),(2,9),(8,8),(0,4),(7,0) -> obj=(10<<10)|20; G1=(1<<10)|1 ... G6=(7<<10)|0; finish_load high for 1 cycle the cycle after the 7th point; busy=1 from that cycle.
- Same stream with in_valid low for 3 cycles between each point -> identical register contents; finish_load still exactly one pulse.
- finish_sort pulsed 14 cycles after finish_load, with in_valid=1 and X=Y=1023 throughout WAIT_SORT -> G1..G6 and obj unchanged; busy falls the cycle after finish_sort; the next point is written to obj.
- finish_sort never returned, TIMEOUT=64 -> err=1 and busy=0 exactly 64 cycles after FIRE; err clears on the next accepted point.
- reset driven low after 4 accepted points, then released -> all outputs 0, no finish_load; a fresh 7-point round completes normally.
- finish_sort pulsed while in LOAD with cnt=3 -> no effect; round continues and finish_load is issued after point 7.
